prog_loader: RTL

Byte-stream program loader between the UART receiver and instruction memory. While `programming` is high, it parses a framed image arriving as received bytes and assembles little-endian 32-bit words. It writes the words to consecutive instruction-memory addresses from word 0, then checks a trailing checksum. It holds the CPU for the whole load and reports completion or failure, so one SoC can program another over its `rxd` line.

---
 rtl/prog_loader_if.sv | 29 ++
 rtl/prog_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/prog_loader_if.sv
// Loader-side bus: the UART byte stream and programming level in, the
// instruction-memory write port and load status out.
interface prog_loader_if #(
    parameter int ADDR_W = 10
);
    logic              programming;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [2:0]        dbg_state;

    // Handshake: rx_valid is a one-cycle strobe with rx_data valid alongside it;
    // there is no ready, every byte is consumed in the cycle it is presented.
    // imem_we is a one-cycle strobe with imem_addr/imem_wdata stable in that cycle.
    modport master (
        output programming, rx_valid, rx_data,
        input  imem_we, imem_addr, imem_wdata, cpu_hold, done, error, dbg_state
    );

    modport slave (
        input  programming, rx_valid, rx_data,
        output imem_we, imem_addr, imem_wdata, cpu_hold, done, error, dbg_state
    );
endinterface

// File: rtl/prog_loader.sv
// Framed byte-stream loader: A5, LEN_LO, LEN_HI, N little-endian words, CSUM.
// Optional inter-byte timeout is compiled in with PROG_LOADER_TIMEOUT_EN.
module prog_loader #(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input logic         clk,
    input logic         reset,
    prog_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SYNC = 3'd1,
        S_LEN0 = 3'd2,
        S_LEN1 = 3'd3,
        S_DATA = 3'd4,
        S_CSUM = 3'd5,
        S_DONE = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    state_t            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        idx_q, idx_d;
    logic [23:0]       word_q, word_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        csum_q, csum_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic [15:0] len_n;
    logic        oversize;
    logic        in_frame;

`ifdef PROG_LOADER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    assign len_n    = {bus.rx_data, len_lo_q};
    assign oversize = {16'd0, len_n} > (32'd1 << ADDR_W);
    assign in_frame = (state_q == S_LEN0) || (state_q == S_LEN1) ||
                      (state_q == S_DATA) || (state_q == S_CSUM);

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        last_d   = last_q;
        addr_d   = addr_q;
        idx_d    = idx_q;
        word_d   = word_q;
        wdata_d  = wdata_q;
        csum_d   = csum_q;
        we_d     = 1'b0;
        done_d   = done_q;
        error_d  = error_q;

        // Address advances after the strobe; the final word leaves DATA, so no wrap.
        if (we_q && state_q == S_DATA) addr_d = addr_q + 1'b1;

        if (in_frame && !bus.programming) begin
            state_d = S_IDLE;
            error_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: if (bus.programming) begin
                    state_d = S_SYNC;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    addr_d  = '0;
                    idx_d   = '0;
                    csum_d  = '0;
                end
                S_SYNC: begin
                    if (!bus.programming) state_d = S_IDLE;
                    else if (bus.rx_valid && bus.rx_data == 8'hA5) state_d = S_LEN0;
                end
                S_LEN0: if (bus.rx_valid) begin
                    len_lo_d = bus.rx_data;
                    state_d  = S_LEN1;
                end
                S_LEN1: if (bus.rx_valid) begin
                    if (oversize) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else if (len_n == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        last_d  = ADDR_W'(len_n - 16'd1);
                        state_d = S_DATA;
                    end
                end
                S_DATA: if (bus.rx_valid) begin
                    csum_d = csum_q + bus.rx_data;
                    idx_d  = idx_q + 1'b1;
                    case (idx_q)
                        2'd0:    word_d[7:0]   = bus.rx_data;
                        2'd1:    word_d[15:8]  = bus.rx_data;
                        2'd2:    word_d[23:16] = bus.rx_data;
                        default: begin
                            we_d    = 1'b1;
                            wdata_d = {bus.rx_data, word_q};
                            if (addr_q == last_q) state_d = S_CSUM;
                        end
                    endcase
                end
                S_CSUM: if (bus.rx_valid) begin
                    if (bus.rx_data == csum_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end
                end
                default: if (!bus.programming) state_d = S_IDLE;
            endcase
        end

`ifdef PROG_LOADER_TIMEOUT_EN
        tmo_d = '0;
        if (in_frame && bus.programming && !bus.rx_valid) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
                state_d = S_ERR;
                error_d = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            len_lo_q <= '0;
            last_q   <= '0;
            addr_q   <= '0;
            idx_q    <= '0;
            word_q   <= '0;
            wdata_q  <= '0;
            csum_q   <= '0;
            we_q     <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
`ifdef PROG_LOADER_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            last_q   <= last_d;
            addr_q   <= addr_d;
            idx_q    <= idx_d;
            word_q   <= word_d;
            wdata_q  <= wdata_d;
            csum_q   <= csum_d;
            we_q     <= we_d;
            done_q   <= done_d;
            error_q  <= error_d;
`ifdef PROG_LOADER_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.cpu_hold   = bus.programming | (state_q != S_IDLE);
    assign bus.dbg_state  = state_q;

endmodule
